// File: rtl/pulse_wave.sv
// Pulse/square oscillator stage: compares the shared phase ramp against a run-time threshold
// and emits a signed +/-amp sample after a 2-clock pipeline. Define SQUARE_SLEW_EN to add a slew limiter.
module pulse_wave #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] THR_DEFAULT = {1'b1, {(ADDR_W-1){1'b0}}},
  parameter logic [DATA_W-2:0] AMP_DEFAULT = {(DATA_W-1){1'b1}},
  parameter int                SLEW_STEP   = 2048
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [ADDR_W-1:0]        i_thr,
  input  logic                     i_thr_vld,
  output logic                     o_thr_rdy,
  input  logic [DATA_W-2:0]        i_amp,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_sync
);

  logic [ADDR_W-1:0]        r_addr_prev;
  logic [ADDR_W-1:0]        r_thr_act;
  logic [ADDR_W-1:0]        r_thr_pend;
  logic                     r_pend_full;
  logic [DATA_W-2:0]        r_amp_act;
  logic                     r_s1_high;
  logic                     r_s1_wrap;
  logic                     r_s1_en;
  logic [DATA_W-2:0]        r_s1_amp;
  logic signed [DATA_W-1:0] r_target;
  logic                     r_sync;

  logic                     w_wrap;
  logic                     w_accept;
  logic                     w_apply;
  logic                     w_amp_upd;
  logic [ADDR_W-1:0]        w_thr_eff;
  logic [DATA_W-2:0]        w_amp_eff;
  logic signed [DATA_W-1:0] w_amp_ext;
  logic signed [DATA_W-1:0] w_target;

  assign w_wrap    = (i_addr < r_addr_prev);
  assign o_thr_rdy = ~r_pend_full;
  // Accept only into an empty slot, so a transfer never coincides with an apply.
  assign w_accept  = i_thr_vld & ~r_pend_full;
  assign w_apply   = r_pend_full & (w_wrap | ~i_en);
  assign w_amp_upd = w_wrap | ~i_en;

  // Values taking effect this cycle are forwarded so a new period is self-consistent.
  assign w_thr_eff = w_apply   ? r_thr_pend : r_thr_act;
  assign w_amp_eff = w_amp_upd ? i_amp      : r_amp_act;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr_prev <= '0;
      r_thr_act   <= THR_DEFAULT;
      r_thr_pend  <= '0;
      r_pend_full <= 1'b0;
      r_amp_act   <= AMP_DEFAULT;
    end else begin
      r_addr_prev <= i_addr;
      r_thr_act   <= w_thr_eff;
      r_amp_act   <= w_amp_eff;
      if (w_accept) begin
        r_thr_pend  <= i_thr;
        r_pend_full <= 1'b1;
      end else if (w_apply) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_high <= 1'b0;
      r_s1_wrap <= 1'b0;
      r_s1_en   <= 1'b0;
      r_s1_amp  <= '0;
    end else begin
      r_s1_high <= (i_addr >= w_thr_eff);
      r_s1_wrap <= w_wrap;
      r_s1_en   <= i_en;
      r_s1_amp  <= w_amp_eff;
    end
  end

  // amp <= 2**(DATA_W-1)-1, so its negation always fits in DATA_W bits.
  assign w_amp_ext = $signed({1'b0, r_s1_amp});

  // NOTE: every path assigns w_target, so no latch can be inferred.
  always_comb begin
    w_target = '0;
    if (r_s1_en) w_target = r_s1_high ? w_amp_ext : -w_amp_ext;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_target <= '0;
      r_sync   <= 1'b0;
    end else begin
      r_target <= w_target;
      r_sync   <= r_s1_wrap & r_s1_en;
    end
  end

  assign o_sync = r_sync;

`ifdef SQUARE_SLEW_EN
  localparam logic signed [DATA_W:0] STEP = (DATA_W+1)'(SLEW_STEP);

  logic signed [DATA_W-1:0] r_slew;
  logic signed [DATA_W:0]   w_diff;
  logic signed [DATA_W:0]   w_slew_nxt;

  // Move toward the target by at most STEP per clock, landing exactly on it.
  always_comb begin
    w_diff     = $signed({r_target[DATA_W-1], r_target}) - $signed({r_slew[DATA_W-1], r_slew});
    w_slew_nxt = $signed({r_target[DATA_W-1], r_target});
    if (w_diff > STEP)       w_slew_nxt = $signed({r_slew[DATA_W-1], r_slew}) + STEP;
    else if (w_diff < -STEP) w_slew_nxt = $signed({r_slew[DATA_W-1], r_slew}) - STEP;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_slew <= '0;
    else       r_slew <= w_slew_nxt[DATA_W-1:0];
  end

  assign o_data = r_slew;
`else
  assign o_data = r_target;
`endif

endmodule

// File: tb/tb_pulse_wave.sv
// Directed bench for pulse_wave (default build): ramp of +4096 per clock, 16 samples per period.
module tb_pulse_wave;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_en;
  logic [15:0]        i_addr;
  logic [15:0]        i_thr;
  logic               i_thr_vld;
  logic               o_thr_rdy;
  logic [14:0]        i_amp;
  logic signed [15:0] o_data;
  logic               o_sync;

  always #5 i_clk = ~i_clk;

  pulse_wave dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_addr   (i_addr),
    .i_thr    (i_thr),
    .i_thr_vld(i_thr_vld),
    .o_thr_rdy(o_thr_rdy),
    .i_amp    (i_amp),
    .o_data   (o_data),
    .o_sync   (o_sync)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected-wave state: the test sets the threshold/amp it knows is active for each sample.
  int          ph;
  logic [15:0] tb_prev;
  logic [15:0] exp_thr;
  int          exp_amp;
  logic        exp_en;

  logic signed [15:0] q_d[$];
  logic               q_s[$];
  string              q_n[$];

  task automatic clear_pipe();
    q_d.delete();
    q_s.delete();
    q_n.delete();
    ph      = 0;
    tb_prev = 16'h0000;
  endtask

  // Called at a negedge: checks the sample driven two cycles ago, drives the next one.
  task automatic cyc(input string nm);
    logic [15:0]        a;
    logic signed [15:0] ed;
    logic               es;
    if (q_d.size() == 2) begin
      logic signed [15:0] d;
      logic               s;
      string              n;
      d = q_d.pop_front();
      s = q_s.pop_front();
      n = q_n.pop_front();
      n_cmp++;
      if (o_data !== d) begin
        n_bad++;
        $display("FAIL %s data: got %0d expected %0d", n, o_data, d);
      end
      n_cmp++;
      if (o_sync !== s) begin
        n_bad++;
        $display("FAIL %s sync: got %b expected %b", n, o_sync, s);
      end
    end
    a  = 16'(ph * 4096);
    es = exp_en && (a < tb_prev);
    if (!exp_en)          ed = 16'sd0;
    else if (a < exp_thr) ed = 16'(-exp_amp);
    else                  ed = 16'(exp_amp);
    tb_prev = a;
    i_addr  = a;
    i_en    = exp_en;
    q_d.push_back(ed);
    q_s.push_back(es);
    q_n.push_back($sformatf("%s[ph=%0d]", nm, ph));
    ph++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic run(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(nm);
  endtask

  task automatic run_to(input int pos, input string nm);
    while ((ph % 16) != pos) cyc(nm);
  endtask

  task automatic check_rdy(input logic exp, input string nm);
    n_cmp++;
    if (o_thr_rdy !== exp) begin
      n_bad++;
      $display("FAIL %s rdy: got %b expected %b", nm, o_thr_rdy, exp);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if (o_data !== 16'sd0) begin n_bad++; $display("FAIL reset data: got %0d expected 0", o_data); end
    n_cmp++;
    if (o_sync !== 1'b0) begin n_bad++; $display("FAIL reset sync: got %b expected 0", o_sync); end
    check_rdy(1'b1, "reset");
    i_rst = 1'b0;
    clear_pipe();
  endtask

  task automatic test_default_wave();
    cyc("default");
    n_cmp++;
    if (o_data !== 16'sd0) begin n_bad++; $display("FAIL latency: got %0d expected 0 one cycle in", o_data); end
    run(31, "default");
  endtask

  task automatic test_thr_update();
    run_to(4, "thr_pre");
    i_thr = 16'h4000; i_thr_vld = 1'b1;
    cyc("thr_req");
    i_thr_vld = 1'b0;
    check_rdy(1'b0, "thr_after_req");
    run_to(0, "thr_old");
    check_rdy(1'b0, "thr_before_wrap");
    exp_thr = 16'h4000;
    cyc("thr_new");
    check_rdy(1'b1, "thr_after_apply");
    run(15, "thr_new");
  endtask

  task automatic test_back_to_back();
    i_thr = 16'hC000; i_thr_vld = 1'b1;
    cyc("b2b_wrap_req");
    i_thr_vld = 1'b0;
    check_rdy(1'b0, "b2b_after_req");
    run(4, "b2b_old");
    i_thr = 16'h2000; i_thr_vld = 1'b1;
    cyc("b2b_ignored");
    i_thr_vld = 1'b0;
    check_rdy(1'b0, "b2b_still_busy");
    run_to(0, "b2b_old");
    exp_thr = 16'hC000;
    cyc("b2b_new");
    check_rdy(1'b1, "b2b_after_apply");
    run(15, "b2b_new");
  endtask

  task automatic test_amp_mute();
    run(5, "amp_pre");
    i_amp = 15'd1000;
    run_to(0, "amp_held");
    exp_amp = 1000;
    run(16, "amp_new");
    exp_en = 1'b0;
    run(20, "mute");
    check_rdy(1'b1, "mute_rdy");
    exp_en = 1'b1;
    run(10, "unmute");
  endtask

  task automatic test_reset_mid();
    run_to(4, "rst_pre");
    i_thr = 16'h1000; i_thr_vld = 1'b1;
    cyc("rst_req");
    i_thr_vld = 1'b0;
    check_rdy(1'b0, "rst_pending");
    #2 i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_data !== 16'sd0) begin n_bad++; $display("FAIL async_reset data: got %0d expected 0", o_data); end
    n_cmp++;
    if (o_sync !== 1'b0) begin n_bad++; $display("FAIL async_reset sync: got %b expected 0", o_sync); end
    check_rdy(1'b1, "async_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    clear_pipe();
    exp_thr = 16'h8000;
    exp_amp = 32767;
    run(16, "post_rst_default");
    exp_amp = 1000;
    run(20, "post_rst_discard");
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_addr = '0; i_thr = '0; i_thr_vld = 1'b0; i_amp = 15'd32767;
    exp_thr = 16'h8000; exp_amp = 32767; exp_en = 1'b1;
    clear_pipe();
    @(negedge i_clk);
    test_reset();
    test_default_wave();
    test_thr_update();
    test_back_to_back();
    test_amp_mute();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
